controller_tc1_status_poller: RTL and testbench

CONTROLLER_TC1_STATUS_POLLER -- requirements
Module: controller_tc1_status_poller

---
 rtl/controller_tc1_status_poller_pkg.sv | 27 ++
 rtl/controller_tc1_status_poller_if.sv | 28 ++
 rtl/controller_tc1_status_fifo.sv | 56 +++++
 rtl/controller_tc1_status_poller.sv | 132 +++++++++++++
 tb/tb_controller_tc1_status_poller.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/controller_tc1_status_poller_pkg.sv
// Shared types and constants for the TC1 status poller: FSM states,
// PIO register addresses and snapshot geometry.
package controller_tc1_status_poller_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        RD_EDGE,
        CLR_EDGE,
        RD_LVL,
        CAP_LVL,
        PUSH
    } state_t;

    localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
    localparam logic [1:0] PIO_ADDR_EDGE = 2'd3;

    localparam int PIO_W   = 25;
    localparam int SNAP_W  = 2 * PIO_W;
    localparam int TIMER_W = 21;

    function automatic logic [SNAP_W-1:0] pack_snapshot(input logic [PIO_W-1:0] edges,
                                                        input logic [PIO_W-1:0] level);
        return {edges, level};
    endfunction

endpackage

// File: rtl/controller_tc1_status_poller_if.sv
// PIO slave bus plus the snapshot output stream of the status poller.
interface controller_tc1_status_poller_if;
    import controller_tc1_status_poller_pkg::*;

    logic [1:0]        m_address;
    logic              m_chipselect;
    logic              m_write_n;
    logic [31:0]       m_writedata;
    logic [31:0]       m_readdata;
    logic              out_valid;
    logic              out_ready;
    logic [SNAP_W-1:0] out_data;

    modport master (
        output m_address, m_chipselect, m_write_n, m_writedata,
        input  m_readdata,
        output out_valid, out_data,
        input  out_ready
    );

    modport slave (
        input  m_address, m_chipselect, m_write_n, m_writedata,
        output m_readdata,
        input  out_valid, out_data,
        output out_ready
    );

endinterface

// File: rtl/controller_tc1_status_fifo.sv
// Snapshot FIFO: registered occupancy, no write-to-read bypass, and a drop
// pulse when a push meets a full FIFO without a simultaneous pop.
module controller_tc1_status_fifo #(
    parameter int WIDTH = 50,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             drop
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;
    logic             full;
    logic             pop;
    logic             accept;

    // A pop frees the slot the same cycle, so a full FIFO can still accept.
    assign full      = (count == FULL_COUNT);
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    assign accept    = push && (!full || pop);
    assign drop      = push && full && !pop;
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (pop)    rd_ptr <= rd_ptr + 1'b1;
            case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/controller_tc1_status_poller.sv
// Periodically reads and clears the PIO edge-capture register, reads the
// level register, and queues {edges, level} snapshots for a consumer.
module controller_tc1_status_poller
    import controller_tc1_status_poller_pkg::*;
#(
    parameter int POLL_PERIOD = 1000,
    parameter int FIFO_DEPTH  = 4,
    parameter int PUSH_ALL    = 0
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           enable,
    controller_tc1_status_poller_if.master bus,
    output logic                           irq,
    output logic                           overflow,
    input  logic                           clear_overflow
);

    localparam logic [TIMER_W-1:0] RELOAD = TIMER_W'(POLL_PERIOD - 1);

    state_t             state;
    state_t             state_next;
    logic [TIMER_W-1:0] timer;
    logic [TIMER_W-1:0] timer_next;
    logic [PIO_W-1:0]   edges;
    logic [PIO_W-1:0]   level;
    logic               push;
    logic               fifo_drop;
    logic               unused_readdata_hi;

    assign unused_readdata_hi = ^bus.m_readdata[31:PIO_W];
    assign bus.m_writedata    = '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            timer <= '0;
            edges <= '0;
            level <= '0;
        end else begin
            state <= state_next;
            timer <= timer_next;
            if (state == CLR_EDGE) edges <= bus.m_readdata[PIO_W-1:0];
            if (state == CAP_LVL)  level <= bus.m_readdata[PIO_W-1:0];
        end
    end

    // The timer measures the whole period from one poll start to the next,
    // so it keeps counting through the poll states and is only reloaded when
    // a poll starts or polling is (re)enabled from IDLE.
    always_comb begin
        state_next          = state;
        timer_next          = timer;
        bus.m_address       = PIO_ADDR_DATA;
        bus.m_chipselect    = 1'b0;
        bus.m_write_n       = 1'b1;
        push                = 1'b0;
        if (state != IDLE && timer != '0) timer_next = timer - 1'b1;
        case (state)
            IDLE: begin
                if (enable) begin
                    timer_next = RELOAD;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (!enable) begin
                    state_next = IDLE;
                end else if (timer == '0) begin
                    timer_next = RELOAD;
                    state_next = RD_EDGE;
                end
            end
            RD_EDGE: begin
                bus.m_address    = PIO_ADDR_EDGE;
                bus.m_chipselect = 1'b1;
                state_next       = CLR_EDGE;
            end
            CLR_EDGE: begin
                if (bus.m_readdata[PIO_W-1:0] != '0) begin
                    bus.m_address    = PIO_ADDR_EDGE;
                    bus.m_chipselect = 1'b1;
                    bus.m_write_n    = 1'b0;
                end
                state_next = RD_LVL;
            end
            RD_LVL: begin
                bus.m_address    = PIO_ADDR_DATA;
                bus.m_chipselect = 1'b1;
                state_next       = CAP_LVL;
            end
            CAP_LVL: begin
                state_next = PUSH;
            end
            PUSH: begin
                push       = (edges != '0) || (PUSH_ALL != 0);
                state_next = enable ? WAIT : IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    controller_tc1_status_fifo #(
        .WIDTH (SNAP_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (pack_snapshot(edges, level)),
        .out_ready (bus.out_ready),
        .out_valid (bus.out_valid),
        .out_data  (bus.out_data),
        .drop      (fifo_drop)
    );

    // A drop in the same cycle as a clear request wins, so no loss goes unseen.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (fifo_drop) begin
            overflow <= 1'b1;
        end else if (clear_overflow) begin
            overflow <= 1'b0;
        end
    end

    assign irq = bus.out_valid || overflow;

endmodule

// File: tb/tb_controller_tc1_status_poller.sv
// Directed bench for the status poller with a behavioural PIO slave that
// captures rising edges on in_port and returns registered read data.
module tb_controller_tc1_status_poller;
    import controller_tc1_status_poller_pkg::*;

    localparam int P     = 8;
    localparam int DEPTH = 4;

    logic clk            = 1'b0;
    logic reset_n        = 1'b0;
    logic enable         = 1'b0;
    logic clear_overflow = 1'b0;
    logic irq;
    logic overflow;

    int checks = 0;
    int errors = 0;
    int n;

    controller_tc1_status_poller_if bus ();

    controller_tc1_status_poller #(
        .POLL_PERIOD (P),
        .FIFO_DEPTH  (DEPTH),
        .PUSH_ALL    (0)
    ) u_dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .enable         (enable),
        .bus            (bus),
        .irq            (irq),
        .overflow       (overflow),
        .clear_overflow (clear_overflow)
    );

    always #5 clk = ~clk;

    // PIO slave model: the clear write has priority over newly captured edges.
    logic [24:0] in_port  = '0;
    logic [24:0] in_prev  = '0;
    logic [24:0] edge_cap = '0;

    always @(posedge clk) begin
        in_prev <= in_port;
        if (bus.m_chipselect && !bus.m_write_n && bus.m_address == PIO_ADDR_EDGE)
            edge_cap <= '0;
        else
            edge_cap <= edge_cap | (in_port & ~in_prev);
        if (bus.m_chipselect && bus.m_write_n) begin
            if (bus.m_address == PIO_ADDR_EDGE)      bus.m_readdata <= {7'b0, edge_cap};
            else if (bus.m_address == PIO_ADDR_DATA) bus.m_readdata <= {7'b0, in_port};
            else                                     bus.m_readdata <= '0;
        end else begin
            bus.m_readdata <= '0;
        end
    end

    // Bus activity statistics, sampled on the falling edge.
    logic stat_clear = 1'b0;
    int   cycle      = 0;
    int   last_start = -1;
    int   starts     = 0;
    int   writes     = 0;
    int   accesses   = 0;
    int   bad_period = 0;

    always @(negedge clk) begin
        cycle <= cycle + 1;
        if (stat_clear) begin
            starts     <= 0;
            writes     <= 0;
            accesses   <= 0;
            bad_period <= 0;
            last_start <= -1;
        end else begin
            if (bus.m_chipselect) accesses <= accesses + 1;
            if (bus.m_chipselect && !bus.m_write_n) writes <= writes + 1;
            if (bus.m_chipselect && bus.m_write_n && bus.m_address == PIO_ADDR_EDGE) begin
                if (last_start >= 0 && (cycle - last_start) != P) bad_period <= bad_period + 1;
                last_start <= cycle;
                starts     <= starts + 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic en, input logic rdy, input logic clr);
        enable         = en;
        bus.out_ready  = rdy;
        clear_overflow = clr;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic waitPoll(output int ticks);
        logic found;
        found = 1'b0;
        ticks = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            ticks++;
            if (bus.m_chipselect && bus.m_write_n && bus.m_address == PIO_ADDR_EDGE) found = 1'b1;
        end
        checkOutput("poll_start_seen", 64'(found), 64'd1);
    endtask

    // Returns just after a PUSH edge, safely away from the edge-loss window.
    task automatic syncAfterPoll();
        int t;
        waitPoll(t);
        repeat (5) tick();
    endtask

    task automatic clearStats();
        stat_clear = 1'b1;
        tick();
        stat_clear = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        applyStimulus(1'b0, 1'b0, 1'b0);
        reset_n = 1'b0;
        tick();
        tick();

        // Reset values
        checkOutput("rst_out_valid",  64'(bus.out_valid),    64'd0);
        checkOutput("rst_out_data",   64'(bus.out_data),     64'd0);
        checkOutput("rst_irq",        64'(irq),              64'd0);
        checkOutput("rst_overflow",   64'(overflow),         64'd0);
        checkOutput("rst_cs",         64'(bus.m_chipselect), 64'd0);
        checkOutput("rst_write_n",    64'(bus.m_write_n),    64'd1);
        checkOutput("rst_address",    64'(bus.m_address),    64'd0);
        checkOutput("rst_writedata",  64'(bus.m_writedata),  64'd0);
        checkOutput("rst_state",      64'(u_dut.state),      64'(IDLE));
        checkOutput("rst_timer",      64'(u_dut.timer),      64'd0);
        checkOutput("rst_count",      64'(u_dut.u_fifo.count), 64'd0);

        // Bench 1: rising edge on bit 3, single snapshot
        reset_n = 1'b1;
        in_port = 25'h8;
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitPoll(n);
        checkOutput("b1_first_poll_latency", 64'(n), 64'(P + 1));
        tick();
        checkOutput("b1_clr_cs",      64'(bus.m_chipselect), 64'd1);
        checkOutput("b1_clr_write_n", 64'(bus.m_write_n),    64'd0);
        checkOutput("b1_clr_address", 64'(bus.m_address),    64'd3);
        checkOutput("b1_clr_wdata",   64'(bus.m_writedata),  64'd0);
        tick();
        checkOutput("b1_rdlvl_cs",      64'(bus.m_chipselect), 64'd1);
        checkOutput("b1_rdlvl_address", 64'(bus.m_address),    64'd0);
        tick();
        checkOutput("b1_caplvl_cs", 64'(bus.m_chipselect), 64'd0);
        tick();
        checkOutput("b1_push_no_bypass", 64'(bus.out_valid), 64'd0);
        tick();
        checkOutput("b1_out_valid", 64'(bus.out_valid), 64'd1);
        checkOutput("b1_out_data",  64'(bus.out_data),  64'({25'h8, 25'h8}));
        checkOutput("b1_irq",       64'(irq),           64'd1);
        applyStimulus(1'b1, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("b1_popped_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("b1_popped_irq",   64'(irq),           64'd0);

        // Bench 2: quiet inputs for 100 cycles
        clearStats();
        repeat (100) tick();
        checkOutput("b2_writes",      64'(writes),         64'd0);
        checkOutput("b2_bad_period",  64'(bad_period),     64'd0);
        checkOutput("b2_starts_ge12", 64'(starts >= 12),   64'd1);
        checkOutput("b2_out_valid",   64'(bus.out_valid),  64'd0);

        // Bench 3: five edge polls into a depth-4 FIFO with no consumer
        syncAfterPoll();
        for (int i = 0; i < 5; i++) begin
            in_port = in_port | (25'd1 << (10 + i));
            waitPoll(n);
            repeat (5) tick();
            checkOutput($sformatf("b3_count_%0d", i), 64'(u_dut.u_fifo.count),
                        64'((i < 4) ? i + 1 : 4));
            checkOutput($sformatf("b3_overflow_%0d", i), 64'(overflow), 64'(i == 4));
        end
        checkOutput("b3_irq",       64'(irq),           64'd1);
        checkOutput("b3_out_valid", 64'(bus.out_valid), 64'd1);
        checkOutput("b3_head",      64'(bus.out_data),  64'({25'h400, 25'h408}));
        tick();
        checkOutput("b3_head_stable", 64'(bus.out_data), 64'({25'h400, 25'h408}));
        applyStimulus(1'b1, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("b3_ovf_cleared", 64'(overflow),             64'd0);
        checkOutput("b3_irq_held",    64'(irq),                  64'd1);
        checkOutput("b3_count_held",  64'(u_dut.u_fifo.count),   64'd4);

        // Bench 4: full FIFO, consumer ready exactly in the PUSH cycle
        syncAfterPoll();
        in_port = in_port | (25'd1 << 15);
        waitPoll(n);
        repeat (4) tick();
        checkOutput("b4_in_push", 64'(u_dut.state), 64'(PUSH));
        applyStimulus(1'b1, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("b4_count",    64'(u_dut.u_fifo.count), 64'd4);
        checkOutput("b4_overflow", 64'(overflow),           64'd0);
        checkOutput("b4_head",     64'(bus.out_data),       64'({25'h800, 25'hC08}));

        // Drop and clear request in the same cycle: overflow stays set
        syncAfterPoll();
        in_port = in_port | (25'd1 << 16);
        waitPoll(n);
        repeat (4) tick();
        applyStimulus(1'b1, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("b4b_ovf_priority", 64'(overflow), 64'd1);

        // Bench 5: reset asserted in the middle of RD_LVL
        syncAfterPoll();
        in_port = in_port | (25'd1 << 17);
        waitPoll(n);
        tick();
        tick();
        checkOutput("b5_in_rdlvl", 64'(u_dut.state), 64'(RD_LVL));
        #1;
        reset_n = 1'b0;
        #1;
        checkOutput("b5_cs",        64'(bus.m_chipselect), 64'd0);
        checkOutput("b5_write_n",   64'(bus.m_write_n),    64'd1);
        checkOutput("b5_address",   64'(bus.m_address),    64'd0);
        checkOutput("b5_out_valid", 64'(bus.out_valid),    64'd0);
        checkOutput("b5_out_data",  64'(bus.out_data),     64'd0);
        checkOutput("b5_irq",       64'(irq),              64'd0);
        checkOutput("b5_overflow",  64'(overflow),         64'd0);
        checkOutput("b5_state",     64'(u_dut.state),      64'(IDLE));
        tick();
        reset_n = 1'b1;
        waitPoll(n);
        checkOutput("b5_restart_latency", 64'(n), 64'(P + 1));
        repeat (5) tick();
        checkOutput("b5_no_push", 64'(bus.out_valid),      64'd0);
        checkOutput("b5_count",   64'(u_dut.u_fifo.count), 64'd0);

        // Bench 6: enable dropped while waiting
        tick();
        checkOutput("b6_in_wait", 64'(u_dut.state), 64'(WAIT));
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("b6_idle",  64'(u_dut.state),      64'(IDLE));
        checkOutput("b6_no_cs", 64'(bus.m_chipselect), 64'd0);
        clearStats();
        repeat (20) tick();
        checkOutput("b6_no_access",  64'(accesses),    64'd0);
        checkOutput("b6_still_idle", 64'(u_dut.state), 64'(IDLE));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
